// File: rtl/io_periph_bank.sv
// Memory-mapped peripheral bank with N_OUT byte-writable output channels, synchronised and debounced
// buttons, button edge capture (W1C) and a level IRQ. Optional macro SW_DEBOUNCE_EN debounces the switches too.
module io_periph_bank_db #(
    parameter int W         = 4,
    parameter int DB_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sync_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] rise_o
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic [CW-1:0] cnt_q, cnt_d;
            logic          lvl_q, lvl_d;

            // Any sample that agrees with the accepted level restarts the stability count.
            always_comb begin
                cnt_d = cnt_q;
                lvl_d = lvl_q;
                if (sync_i[gi] == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    lvl_d = sync_i[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign level_o[gi] = lvl_q;
            assign rise_o[gi]  = lvl_d & ~lvl_q;
        end
    endgenerate
endmodule

module io_periph_bank #(
    parameter int         N_OUT     = 8,
    parameter int         SW_W      = 18,
    parameter int         BTN_W     = 4,
    parameter int         DB_CYCLES = 250000,
    parameter logic [7:0] BASE_HI   = 8'h70
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          addr,
    input  logic [31:0]          w_data,
    input  logic                 wr_en,
    input  logic [3:0]           bmask,
    output logic [31:0]          r_data,
    output logic                 hit,
    output logic [N_OUT*32-1:0]  o_data,
    input  logic [SW_W-1:0]      i_sw,
    input  logic [BTN_W-1:0]     i_btn,
    output logic                 irq
);
    localparam logic [5:0] N_OUT_L  = 6'(N_OUT);
    localparam logic [5:0] W_SW     = 6'h20;
    localparam logic [5:0] W_BTN    = 6'h21;
    localparam logic [5:0] W_EDGE   = 6'h22;
    localparam logic [5:0] W_IRQ_EN = 6'h23;

    logic [5:0]  widx;
    logic        is_out;
    logic        wr;
    logic [31:0] wmask;
    logic [31:0] wbits;
    logic        unused_addr_lsb;

    assign hit             = (addr[15:8] == BASE_HI);
    assign widx            = addr[7:2];
    assign is_out          = ~addr[7] && ({1'b0, widx[4:0]} < N_OUT_L);
    assign wr              = wr_en & hit;
    assign wmask           = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
    assign wbits           = w_data & wmask;
    assign unused_addr_lsb = ^addr[1:0];

    // Output channels; the read view is padded to 32 entries so the word index can address it directly.
    logic [31:0] ch_rd [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ch
            if (gi < N_OUT) begin : g_real
                logic [31:0] ch_q, ch_d;
                logic        ch_we;

                assign ch_we = wr & is_out & (widx[4:0] == 5'(gi));
                assign ch_d  = ch_we ? ((ch_q & ~wmask) | wbits) : ch_q;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) ch_q <= '0;
                    else      ch_q <= ch_d;
                end

                assign ch_rd[gi]              = ch_q;
                assign o_data[32*gi +: 32]    = ch_q;
            end else begin : g_pad
                assign ch_rd[gi] = '0;
            end
        end
    endgenerate

    // Two-flop synchronisers for every raw input bit.
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic [BTN_W-1:0] btn_s1_q, btn_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            sw_s1_q  <= i_sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= i_btn;
            btn_s2_q <= btn_s1_q;
        end
    end

    logic [SW_W-1:0]  sw_val;
    logic [BTN_W-1:0] btn_lvl;
    logic [BTN_W-1:0] btn_rise;

    io_periph_bank_db #(.W(BTN_W), .DB_CYCLES(DB_CYCLES)) u_btn_db (
        .clk     (clk),
        .rst     (rst),
        .sync_i  (btn_s2_q),
        .level_o (btn_lvl),
        .rise_o  (btn_rise)
    );

`ifdef SW_DEBOUNCE_EN
    logic [SW_W-1:0] sw_rise_unused;

    io_periph_bank_db #(.W(SW_W), .DB_CYCLES(DB_CYCLES)) u_sw_db (
        .clk     (clk),
        .rst     (rst),
        .sync_i  (sw_s2_q),
        .level_o (sw_val),
        .rise_o  (sw_rise_unused)
    );
`else
    assign sw_val = sw_s2_q;
`endif

    logic [BTN_W-1:0] edge_q, edge_d;
    logic [BTN_W-1:0] irq_en_q, irq_en_d;
    logic [BTN_W-1:0] edge_clr;
    logic             irq_q;

    // A rising level in the same cycle as a clear leaves the bit set.
    always_comb begin
        edge_clr = '0;
        irq_en_d = irq_en_q;
        if (wr && widx == W_EDGE)   edge_clr = wbits[BTN_W-1:0];
        if (wr && widx == W_IRQ_EN) irq_en_d = (irq_en_q & ~wmask[BTN_W-1:0]) | wbits[BTN_W-1:0];
        edge_d = (edge_q & ~edge_clr) | btn_rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q   <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            irq_q    <= |(edge_q & irq_en_q);
        end
    end

    assign irq = irq_q;

    always_comb begin
        r_data = '0;
        if (hit) begin
            if (is_out) begin
                r_data = ch_rd[widx[4:0]];
            end else begin
                case (widx)
                    W_SW:     r_data[SW_W-1:0]  = sw_val;
                    W_BTN:    r_data[BTN_W-1:0] = btn_lvl;
                    W_EDGE:   r_data[BTN_W-1:0] = edge_q;
                    W_IRQ_EN: r_data[BTN_W-1:0] = irq_en_q;
                    default:  r_data = '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_io_periph_bank.sv
// Directed bench for io_periph_bank with DB_CYCLES=4, one task per feature.
module tb_io_periph_bank;
    localparam int N_OUT = 8;
    localparam int SW_W  = 18;
    localparam int BTN_W = 4;
    localparam int DB    = 4;
`ifdef SW_DEBOUNCE_EN
    localparam int SW_LAT = 2 + DB;
`else
    localparam int SW_LAT = 2;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [15:0]         addr = '0;
    logic [31:0]         w_data = '0;
    logic                wr_en = 1'b0;
    logic [3:0]          bmask = '0;
    logic [31:0]         r_data;
    logic                hit;
    logic [N_OUT*32-1:0] o_data;
    logic [SW_W-1:0]     i_sw = '0;
    logic [BTN_W-1:0]    i_btn = '0;
    logic                irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    io_periph_bank #(
        .N_OUT(N_OUT), .SW_W(SW_W), .BTN_W(BTN_W), .DB_CYCLES(DB), .BASE_HI(8'h70)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .w_data(w_data), .wr_en(wr_en), .bmask(bmask),
        .r_data(r_data), .hit(hit), .o_data(o_data), .i_sw(i_sw), .i_btn(i_btn), .irq(irq)
    );

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr = a; w_data = d; bmask = m; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        $display("wr addr=%h data=%h mask=%b", a, d, m);
    endtask

    task automatic rd(input logic [15:0] a);
        addr = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N_OUT; i++) begin
            rd(16'h7000 + 16'(4 * i));
            total_cnt++;
            if (r_data !== 32'h0) $display("FAIL reset_ch%0d got=%h exp=0", i, r_data);
            else pass_cnt++;
        end
        rd(16'h7088);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL reset_edge got=%h exp=0", r_data); else pass_cnt++;
        rd(16'h708C);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL reset_irq_en got=%h exp=0", r_data); else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else pass_cnt++;
        total_cnt++;
        if (o_data !== '0) $display("FAIL reset_o_data got=%h exp=0", o_data); else pass_cnt++;
        $display("reset checks done");
    endtask

    task automatic test_out_channels();
        wr(16'h7008, 32'hDEADBEEF, 4'b1111);
        wr(16'h7008, 32'h00000055, 4'b0001);
        rd(16'h7008);
        total_cnt++;
        if (r_data !== 32'hDEADBE55) $display("FAIL ch2_bytemask got=%h exp=DEADBE55", r_data); else pass_cnt++;
        total_cnt++;
        if (o_data[95:64] !== 32'hDEADBE55) $display("FAIL ch2_o_data got=%h exp=DEADBE55", o_data[95:64]); else pass_cnt++;
        rd(16'h700B);
        total_cnt++;
        if (r_data !== 32'hDEADBE55) $display("FAIL ch2_addr_lsb got=%h exp=DEADBE55", r_data); else pass_cnt++;
        wr(16'h7020, 32'h12345678, 4'b1111);
        rd(16'h7020);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL ch8_unmapped got=%h exp=0", r_data); else pass_cnt++;
        wr(16'h701C, 32'hA5A5_0000, 4'b1100);
        rd(16'h701C);
        total_cnt++;
        if (r_data !== 32'hA5A50000) $display("FAIL ch7 got=%h exp=A5A50000", r_data); else pass_cnt++;
        total_cnt++;
        if (o_data[255:224] !== 32'hA5A50000) $display("FAIL ch7_o_data got=%h exp=A5A50000", o_data[255:224]); else pass_cnt++;
        wr(16'h6008, 32'h0, 4'b1111);
        rd(16'h6008);
        total_cnt++;
        if (hit !== 1'b0 || r_data !== 32'h0) $display("FAIL miss_read hit=%b data=%h exp=0/0", hit, r_data); else pass_cnt++;
        rd(16'h7008);
        total_cnt++;
        if (r_data !== 32'hDEADBE55) $display("FAIL miss_write_ignored got=%h exp=DEADBE55", r_data); else pass_cnt++;
    endtask

    task automatic test_debounce();
        // 3-cycle glitch must not be accepted.
        @(negedge clk); i_btn = 4'h2;
        repeat (3) @(negedge clk);
        i_btn = 4'h0;
        repeat (6) @(negedge clk);
        rd(16'h7084);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL glitch_btn got=%h exp=0", r_data); else pass_cnt++;
        rd(16'h7088);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL glitch_edge got=%h exp=0", r_data); else pass_cnt++;
        @(negedge clk); i_btn = 4'h2;
        repeat (5) @(negedge clk);
        rd(16'h7084);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL btn_early got=%h exp=0", r_data); else pass_cnt++;
        @(negedge clk);
        rd(16'h7084);
        total_cnt++;
        if (r_data !== 32'h2) $display("FAIL btn_level got=%h exp=2", r_data); else pass_cnt++;
        rd(16'h7088);
        total_cnt++;
        if (r_data !== 32'h2) $display("FAIL btn_edge got=%h exp=2", r_data); else pass_cnt++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_irq();
        wr(16'h708C, 32'hFFFFFFFF, 4'b1111);
        rd(16'h708C);
        total_cnt++;
        if (r_data !== 32'h0000000F) $display("FAIL irq_en_width got=%h exp=F", r_data); else pass_cnt++;
        wr(16'h708C, 32'h0, 4'b1111);
        @(negedge clk);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_off got=%b exp=0", irq); else pass_cnt++;
        wr(16'h708C, 32'h2, 4'b0001);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_not_yet got=%b exp=0", irq); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_assert got=%b exp=1", irq); else pass_cnt++;
        wr(16'h7088, 32'h2, 4'b1110);
        rd(16'h7088);
        total_cnt++;
        if (r_data !== 32'h2) $display("FAIL w1c_masked got=%h exp=2", r_data); else pass_cnt++;
        wr(16'h7088, 32'h2, 4'b0001);
        rd(16'h7088);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL w1c_clear got=%h exp=0", r_data); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_deassert got=%b exp=0", irq); else pass_cnt++;
        // Release, then re-press so the new edge lands on the same clock as a clear.
        i_btn = 4'h0;
        repeat (7) @(negedge clk);
        i_btn = 4'h2;
        repeat (5) @(negedge clk);
        addr = 16'h7088; w_data = 32'h2; bmask = 4'b0001; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        $display("wr addr=7088 data=00000002 mask=0001 (with new edge)");
        rd(16'h7088);
        total_cnt++;
        if (r_data !== 32'h2) $display("FAIL set_wins got=%h exp=2", r_data); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_reassert got=%b exp=1", irq); else pass_cnt++;
    endtask

    task automatic test_switches();
        @(negedge clk); i_sw = 18'h2A5A5;
        repeat (SW_LAT - 1) @(negedge clk);
        rd(16'h7080);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL sw_early got=%h exp=0", r_data); else pass_cnt++;
        @(negedge clk);
        rd(16'h7080);
        total_cnt++;
        if (r_data !== 32'h0002A5A5) $display("FAIL sw_read got=%h exp=0002A5A5", r_data); else pass_cnt++;
        wr(16'h7080, 32'h0, 4'b1111);
        wr(16'h7084, 32'hF, 4'b1111);
        rd(16'h7080);
        total_cnt++;
        if (r_data !== 32'h0002A5A5) $display("FAIL sw_ro got=%h exp=0002A5A5", r_data); else pass_cnt++;
        rd(16'h7090);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL unmapped_90 got=%h exp=0", r_data); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        i_btn = 4'h0;
        repeat (3) @(negedge clk);
        addr = 16'h7084;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (o_data !== '0) $display("FAIL async_o_data got=%h exp=0", o_data); else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL async_irq got=%b exp=0", irq); else pass_cnt++;
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL async_btn got=%h exp=0", r_data); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        rd(16'h7080);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL async_sw got=%h exp=0", r_data); else pass_cnt++;
        rd(16'h7008);
        total_cnt++;
        if (r_data !== 32'h0) $display("FAIL async_ch2 got=%h exp=0", r_data); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_out_channels();
        test_debounce();
        test_irq();
        test_switches();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
